// File: rtl/kernel_seq_pkg.sv
// Shared types for the kernel sequencer: ISA field encodings, FSM states and
// the loop-stack entry layout.
package kernel_seq_pkg;

  typedef enum logic [1:0] {
    OP_MEM  = 2'b00,
    OP_PROC = 2'b01,
    OP_LOOP = 2'b10,
    OP_HALT = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    LOOP_BEGIN_IND = 2'b00,
    LOOP_BEGIN_DEP = 2'b01,
    LOOP_ILLEGAL   = 2'b10,
    LOOP_END       = 2'b11
  } loop_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_ISSUE
  } state_e;

  // Field widths; the opcode sits in the top OPCODE_W bits of an instruction,
  // the loop sub-op directly below it.
  localparam int OPCODE_W = 2;
  localparam int SUBOP_W  = 2;

  // Wide enough for any supported COUNT_WIDTH; counts are zero-extended.
  localparam int REMAINING_W = 16;

  typedef struct packed {
    logic [REMAINING_W-1:0] remaining;
    logic                   independent;
  } loop_entry_t;

endpackage

// File: rtl/kernel_sequencer_loop_stack.sv
// Loop nesting stack: push/pop/step-down of the innermost entry, plus the
// batching step (min(remaining, superscalar width) for independent loops).
module loop_stack
  import kernel_seq_pkg::*;
#(
  parameter int LOOP_LOG_DEPTH        = 3,
  parameter int SUPERSCALAR_LOG_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   step_down,
  input  logic [REMAINING_W-1:0] push_count,
  input  logic                   push_independent,
  output logic                   top_independent,
  output logic [REMAINING_W-1:0] step,
  output logic                   last,
  output logic                   empty,
  output logic                   full
);

  localparam int DEPTH = 1 << LOOP_LOG_DEPTH;
  localparam int WIDTH = 1 << SUPERSCALAR_LOG_WIDTH;
  localparam logic [LOOP_LOG_DEPTH:0] SP_ONE = 1;

  loop_entry_t               entries [DEPTH];
  loop_entry_t               top;
  logic [LOOP_LOG_DEPTH:0]   sp;
  logic [LOOP_LOG_DEPTH-1:0] top_idx;
  logic [LOOP_LOG_DEPTH-1:0] push_idx;

  assign top_idx  = LOOP_LOG_DEPTH'(sp - SP_ONE);
  assign push_idx = sp[LOOP_LOG_DEPTH-1:0];
  assign empty    = (sp == '0);
  assign full     = sp[LOOP_LOG_DEPTH];
  assign top      = entries[top_idx];

  assign top_independent = top.independent & ~empty;

  always_comb begin
    step = REMAINING_W'(1);
    if (top.independent)
      step = (top.remaining < REMAINING_W'(WIDTH)) ? top.remaining : REMAINING_W'(WIDTH);
  end

  assign last = (top.remaining <= step);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          sp <= '0;
    else if (clear)     sp <= '0;
    else if (push)      sp <= sp + SP_ONE;
    else if (pop)       sp <= sp - SP_ONE;
  end

  // A level that gains a child is no longer innermost, so it stops batching.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      entries[push_idx] <= '{remaining: push_count, independent: push_independent};
      if (!empty) entries[top_idx].independent <= 1'b0;
    end else if (step_down && !clear) begin
      entries[top_idx].remaining <= top.remaining - step;
    end
  end

endmodule

// File: rtl/kernel_sequencer.sv
// Fetch/decode/issue controller with a hardware loop stack; batches the
// innermost independent loop into superscalar copies on the memory port.
module kernel_sequencer
  import kernel_seq_pkg::*;
#(
  parameter int ISA_WIDTH             = 18,
  parameter int ADDR_WIDTH            = 18,
  parameter int COUNT_WIDTH           = 14,
  parameter int LOOP_LOG_DEPTH        = 3,
  parameter int SUPERSCALAR_LOG_WIDTH = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             kernel_start,
  input  logic [ADDR_WIDTH-1:0]            kernel_start_pc,
  output logic [ADDR_WIDTH-1:0]            pc,
  input  logic [ISA_WIDTH-1:0]             raw_instruction,
  output logic [ISA_WIDTH-3:0]             mem_instr,
  output logic                             mem_valid,
  input  logic                             mem_ready,
  output logic [ISA_WIDTH-3:0]             proc_instr,
  output logic                             proc_valid,
  input  logic                             proc_ready,
  output logic [SUPERSCALAR_LOG_WIDTH-1:0] copy_count,
  output logic                             busy,
  output logic                             done,
  output logic                             error
);

  localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE = 1;
  localparam logic [REMAINING_W-1:0] REM_ONE  = 1;

  state_e                           state, state_n;
  logic [ADDR_WIDTH-1:0]            pc_n;
  logic                             busy_n, done_n, error_n, halt;
  logic                             load_issue;
  logic [ISA_WIDTH-3:0]             payload_q;
  logic                             is_mem_q;
  logic [SUPERSCALAR_LOG_WIDTH-1:0] copy_q, copy_n;

  opcode_e                          op;
  loop_op_e                         sub;
  logic [COUNT_WIDTH-1:0]           arg;
  logic [REMAINING_W-1:0]           push_count;

  logic                             st_push, st_pop, st_step, st_clear;
  logic                             st_top_indep, st_last, st_empty, st_full;
  logic [REMAINING_W-1:0]           st_step_amt;

  assign op  = opcode_e'(raw_instruction[ISA_WIDTH-1 -: OPCODE_W]);
  assign sub = loop_op_e'(raw_instruction[ISA_WIDTH-1-OPCODE_W -: SUBOP_W]);
  assign arg = raw_instruction[COUNT_WIDTH-1:0];
  assign push_count = (arg == '0) ? REM_ONE : REMAINING_W'(arg);

  assign copy_n = (op == OP_MEM && st_top_indep) ?
                  SUPERSCALAR_LOG_WIDTH'(st_step_amt - REM_ONE) : '0;

  loop_stack #(
    .LOOP_LOG_DEPTH       (LOOP_LOG_DEPTH),
    .SUPERSCALAR_LOG_WIDTH(SUPERSCALAR_LOG_WIDTH)
  ) u_loop_stack (
    .clk             (clk),
    .reset           (reset),
    .clear           (st_clear),
    .push            (st_push),
    .pop             (st_pop),
    .step_down       (st_step),
    .push_count      (push_count),
    .push_independent(sub == LOOP_BEGIN_IND),
    .top_independent (st_top_indep),
    .step            (st_step_amt),
    .last            (st_last),
    .empty           (st_empty),
    .full            (st_full)
  );

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    busy_n     = busy;
    done_n     = 1'b0;
    error_n    = error;
    halt       = 1'b0;
    load_issue = 1'b0;
    st_push    = 1'b0;
    st_pop     = 1'b0;
    st_step    = 1'b0;
    st_clear   = 1'b0;
    case (state)
      S_IDLE: begin
        if (kernel_start) begin
          pc_n    = kernel_start_pc;
          busy_n  = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_FETCH: state_n = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_MEM, OP_PROC: begin
            load_issue = 1'b1;
            state_n    = S_ISSUE;
          end
          OP_LOOP: begin
            case (sub)
              LOOP_BEGIN_IND, LOOP_BEGIN_DEP: begin
                if (st_full) begin
                  error_n = 1'b1;
                  halt    = 1'b1;
                end else begin
                  st_push = 1'b1;
                  pc_n    = pc + ADDR_ONE;
                  state_n = S_FETCH;
                end
              end
              LOOP_END: begin
                if (st_empty) begin
                  error_n = 1'b1;
                  halt    = 1'b1;
                end else if (st_last) begin
                  st_pop  = 1'b1;
                  pc_n    = pc + ADDR_ONE;
                  state_n = S_FETCH;
                end else begin
                  st_step = 1'b1;
                  pc_n    = pc - ADDR_WIDTH'(arg);
                  state_n = S_FETCH;
                end
              end
              default: begin
                error_n = 1'b1;
                halt    = 1'b1;
              end
            endcase
          end
          default: halt = 1'b1;
        endcase
        if (halt) begin
          busy_n   = 1'b0;
          done_n   = 1'b1;
          st_clear = 1'b1;
          state_n  = S_IDLE;
        end
      end
      S_ISSUE: begin
        if ((mem_valid && mem_ready) || (proc_valid && proc_ready)) begin
          pc_n    = pc + ADDR_ONE;
          state_n = S_FETCH;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      pc    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      busy  <= busy_n;
      done  <= done_n;
      error <= error_n;
    end
  end

  // Issue payload is captured once and held for the whole handshake.
  always_ff @(posedge clk) begin
    if (load_issue) begin
      payload_q <= raw_instruction[ISA_WIDTH-3:0];
      is_mem_q  <= (op == OP_MEM);
      copy_q    <= copy_n;
    end
  end

  assign mem_valid  = (state == S_ISSUE) &&  is_mem_q;
  assign proc_valid = (state == S_ISSUE) && !is_mem_q;
  assign mem_instr  = mem_valid  ? payload_q : '0;
  assign proc_instr = proc_valid ? payload_q : '0;
  assign copy_count = mem_valid  ? copy_q    : '0;

endmodule

// File: tb/tb_kernel_sequencer.sv
// Self-checking bench for kernel_sequencer: single-instruction vector table
// plus hand-written loop, backpressure, overflow and async-reset sequences.
module tb_kernel_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        kernel_start = 1'b0;
  logic [17:0] kernel_start_pc = '0;
  logic [17:0] pc;
  logic [17:0] raw_instruction = '0;
  logic [15:0] mem_instr, proc_instr;
  logic        mem_valid, proc_valid;
  logic        mem_ready = 1'b1, proc_ready = 1'b1;
  logic [1:0]  copy_count;
  logic        busy, done, error;

  kernel_sequencer dut (
    .clk(clk), .reset(reset), .kernel_start(kernel_start),
    .kernel_start_pc(kernel_start_pc), .pc(pc), .raw_instruction(raw_instruction),
    .mem_instr(mem_instr), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .proc_instr(proc_instr), .proc_valid(proc_valid), .proc_ready(proc_ready),
    .copy_count(copy_count), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  localparam logic [17:0] I_HALT = 18'h30000;
  logic [17:0] rom [256];
  always @(posedge clk) raw_instruction <= rom[pc[7:0]];

  function automatic logic [17:0] i_mem(input logic [15:0] p);
    return {2'b00, p};
  endfunction
  function automatic logic [17:0] i_proc(input logic [15:0] p);
    return {2'b01, p};
  endfunction
  function automatic logic [17:0] i_loop(input logic [1:0] s, input logic [13:0] a);
    return {2'b10, s, a};
  endfunction

  typedef struct {
    logic        is_mem;
    logic [15:0] payload;
    logic [1:0]  cc;
  } exp_t;

  typedef struct {
    string       name;
    logic [17:0] instr;
    logic        exp_issue;
    logic        exp_mem;
    logic [15:0] exp_payload;
    logic        exp_err;
  } vec_t;

  exp_t        sbq[$];
  exp_t        e;
  logic [17:0] pc_trace[$];
  int          tests = 0, fails = 0;
  int          n_mem_hs = 0, n_proc_hs = 0, n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard / monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        n_done++;
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
      end
      if (busy && (pc_trace.size() == 0 || pc_trace[$] != pc)) pc_trace.push_back(pc);
      if ((mem_valid && mem_ready) || (proc_valid && proc_ready)) begin
        if (mem_valid) n_mem_hs++; else n_proc_hs++;
        if (sbq.size() == 0) begin
          check("issue_expected", 32'(sbq.size()), 32'd1);
        end else begin
          e = sbq.pop_front();
          check("issue_kind", {31'd0, mem_valid}, {31'd0, e.is_mem});
          check("issue_payload", {16'd0, mem_valid ? mem_instr : proc_instr}, {16'd0, e.payload});
          if (e.is_mem) check("copy_count", {30'd0, copy_count}, {30'd0, e.cc});
        end
      end
    end
  end

  task automatic clear_sb();
    sbq.delete();
    pc_trace.delete();
    n_mem_hs = 0;
    n_proc_hs = 0;
    n_done = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ":pc"}, {14'd0, pc}, 32'd0);
    check({tag, ":busy"}, {31'd0, busy}, 32'd0);
    check({tag, ":done"}, {31'd0, done}, 32'd0);
    check({tag, ":error"}, {31'd0, error}, 32'd0);
    check({tag, ":mem_valid"}, {31'd0, mem_valid}, 32'd0);
    check({tag, ":proc_valid"}, {31'd0, proc_valid}, 32'd0);
    check({tag, ":copy_count"}, {30'd0, copy_count}, 32'd0);
  endtask

  task automatic do_reset();
    mem_ready = 1'b1;
    proc_ready = 1'b1;
    kernel_start = 1'b0;
    #2 reset = 1'b1;
    #1;
    clear_sb();
    check_reset_outputs("reset");
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_kernel(input logic [17:0] spc, input int budget, input string name);
    int start_done;
    int cyc;
    start_done = n_done;
    @(posedge clk);
    #1 kernel_start = 1'b1;
    kernel_start_pc = spc;
    @(posedge clk);
    #1 kernel_start = 1'b0;
    cyc = 0;
    while (n_done == start_done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check({name, ":done_seen"}, {31'd0, n_done != start_done}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  vec_t vecs[7];

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = I_HALT;

    vecs[0] = '{"v_mem",        i_mem(16'hBEEF),        1'b1, 1'b1, 16'hBEEF, 1'b0};
    vecs[1] = '{"v_proc",       i_proc(16'h1234),       1'b1, 1'b0, 16'h1234, 1'b0};
    vecs[2] = '{"v_mem_zero",   i_mem(16'h0000),        1'b1, 1'b1, 16'h0000, 1'b0};
    vecs[3] = '{"v_proc_max",   i_proc(16'hFFFF),       1'b1, 1'b0, 16'hFFFF, 1'b0};
    vecs[4] = '{"v_illegal",    i_loop(2'b10, 14'd5),   1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{"v_end_empty",  i_loop(2'b11, 14'd1),   1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[6] = '{"v_halt",       I_HALT,                 1'b0, 1'b0, 16'h0000, 1'b0};

    #1;
    do_reset();

    // Table of single-instruction kernels.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      rom[8'h60] = vecs[i].instr;
      rom[8'h61] = I_HALT;
      if (vecs[i].exp_issue) sbq.push_back('{vecs[i].exp_mem, vecs[i].exp_payload, 2'd0});
      run_kernel(18'h60, 40, vecs[i].name);
      check({vecs[i].name, ":error"}, {31'd0, error}, {31'd0, vecs[i].exp_err});
      check({vecs[i].name, ":issues"}, 32'(n_mem_hs + n_proc_hs), {31'd0, vecs[i].exp_issue});
      check({vecs[i].name, ":sb_drained"}, 32'(sbq.size()), 32'd0);
    end

    // Straight line: mem, proc, halt.
    do_reset();
    rom[8'h10] = i_mem(16'h1111);
    rom[8'h11] = i_proc(16'h2222);
    rom[8'h12] = I_HALT;
    sbq.push_back('{1'b1, 16'h1111, 2'd0});
    sbq.push_back('{1'b0, 16'h2222, 2'd0});
    run_kernel(18'h10, 40, "straight");
    check("straight:trace_len", 32'(pc_trace.size()), 32'd3);
    if (pc_trace.size() == 3) begin
      check("straight:pc0", {14'd0, pc_trace[0]}, 32'h10);
      check("straight:pc1", {14'd0, pc_trace[1]}, 32'h11);
      check("straight:pc2", {14'd0, pc_trace[2]}, 32'h12);
    end
    check("straight:mem_hs", 32'(n_mem_hs), 32'd1);
    check("straight:proc_hs", 32'(n_proc_hs), 32'd1);
    check("straight:done_count", 32'(n_done), 32'd1);

    // Backpressure on the processing port.
    do_reset();
    rom[8'h50] = i_proc(16'h0777);
    rom[8'h51] = I_HALT;
    sbq.push_back('{1'b0, 16'h0777, 2'd0});
    proc_ready = 1'b0;
    @(posedge clk);
    #1 kernel_start = 1'b1;
    kernel_start_pc = 18'h50;
    @(posedge clk);
    #1 kernel_start = 1'b0;
    for (int c = 0; c < 20 && !proc_valid; c++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp:valid_held", {31'd0, proc_valid}, 32'd1);
      check("bp:payload_held", {16'd0, proc_instr}, 32'h0777);
      check("bp:pc_held", {14'd0, pc}, 32'h50);
      @(posedge clk);
      #1;
      if (i == 4) proc_ready = 1'b1;
      @(negedge clk);
    end
    check("bp:valid_6th", {31'd0, proc_valid}, 32'd1);
    check("bp:payload_6th", {16'd0, proc_instr}, 32'h0777);
    for (int c = 0; c < 20 && n_done == 0; c++) @(negedge clk);
    check("bp:done", 32'(n_done), 32'd1);
    check("bp:handshakes", 32'(n_proc_hs), 32'd1);

    // Independent loop, count 10, batched by 4.
    do_reset();
    rom[8'h20] = i_loop(2'b00, 14'd10);
    rom[8'h21] = i_mem(16'hA5A5);
    rom[8'h22] = i_loop(2'b11, 14'd1);
    rom[8'h23] = I_HALT;
    sbq.push_back('{1'b1, 16'hA5A5, 2'd3});
    sbq.push_back('{1'b1, 16'hA5A5, 2'd3});
    sbq.push_back('{1'b1, 16'hA5A5, 2'd1});
    run_kernel(18'h20, 200, "indep");
    check("indep:mem_hs", 32'(n_mem_hs), 32'd3);
    check("indep:error", {31'd0, error}, 32'd0);
    check("indep:trace_len", 32'(pc_trace.size()), 32'd8);
    if (pc_trace.size() > 0) check("indep:last_pc", {14'd0, pc_trace[$]}, 32'h23);

    // Nested dependent loops 3 x 2.
    do_reset();
    rom[8'h30] = i_loop(2'b01, 14'd3);
    rom[8'h31] = i_loop(2'b01, 14'd2);
    rom[8'h32] = i_mem(16'h0B0B);
    rom[8'h33] = i_loop(2'b11, 14'd1);
    rom[8'h34] = i_loop(2'b11, 14'd3);
    rom[8'h35] = I_HALT;
    rom[8'h38] = i_loop(2'b11, 14'd1);
    rom[8'h39] = I_HALT;
    for (int i = 0; i < 6; i++) sbq.push_back('{1'b1, 16'h0B0B, 2'd0});
    run_kernel(18'h30, 400, "nested");
    check("nested:mem_hs", 32'(n_mem_hs), 32'd6);
    check("nested:error", {31'd0, error}, 32'd0);
    run_kernel(18'h38, 40, "nested_empty");
    check("nested_empty:error", {31'd0, error}, 32'd1);

    // Halt discards open loop levels.
    do_reset();
    rom[8'h70] = i_loop(2'b01, 14'd4);
    rom[8'h71] = I_HALT;
    rom[8'h72] = i_loop(2'b11, 14'd1);
    rom[8'h73] = I_HALT;
    run_kernel(18'h70, 40, "halt_push");
    check("halt_push:error", {31'd0, error}, 32'd0);
    run_kernel(18'h72, 40, "halt_clears");
    check("halt_clears:error", {31'd0, error}, 32'd1);

    // Overflow on the ninth push.
    do_reset();
    for (int i = 0; i < 9; i++) rom[8'h40 + i] = i_loop(2'b00, 14'd1);
    rom[8'h49] = I_HALT;
    run_kernel(18'h40, 100, "ovf");
    check("ovf:error", {31'd0, error}, 32'd1);
    check("ovf:done_count", 32'(n_done), 32'd1);
    check("ovf:halt_pc", {14'd0, pc}, 32'h48);
    check("ovf:busy", {31'd0, busy}, 32'd0);
    clear_sb();
    sbq.push_back('{1'b1, 16'h1111, 2'd0});
    sbq.push_back('{1'b0, 16'h2222, 2'd0});
    run_kernel(18'h10, 40, "ovf_rerun");
    check("ovf_rerun:issues", 32'(n_mem_hs + n_proc_hs), 32'd2);
    check("ovf_rerun:error_sticky", {31'd0, error}, 32'd1);

    // Asynchronous reset while a memory issue is stalled.
    clear_sb();
    mem_ready = 1'b0;
    @(posedge clk);
    #1 kernel_start = 1'b1;
    kernel_start_pc = 18'h10;
    @(posedge clk);
    #1 kernel_start = 1'b0;
    for (int c = 0; c < 20 && !mem_valid; c++) @(negedge clk);
    check("arst:valid_before", {31'd0, mem_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst:mem_valid", {31'd0, mem_valid}, 32'd0);
    check("arst:busy", {31'd0, busy}, 32'd0);
    check("arst:error", {31'd0, error}, 32'd0);
    check("arst:done", {31'd0, done}, 32'd0);
    clear_sb();
    @(posedge clk);
    #1 reset = 1'b0;
    mem_ready = 1'b1;
    sbq.push_back('{1'b1, 16'h1111, 2'd0});
    sbq.push_back('{1'b0, 16'h2222, 2'd0});
    run_kernel(18'h10, 40, "arst_rerun");
    check("arst_rerun:issues", 32'(n_mem_hs + n_proc_hs), 32'd2);
    check("arst_rerun:done_count", 32'(n_done), 32'd1);
    check("arst_rerun:sb_drained", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
